// File: rtl/icache_burst_refill_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// icache_burst_refill_if : fetch-side (ufp) and refill-side (dfp) bus bundle
// Rev 1.0
// ----------------------------------------------------------------------------
interface icache_burst_refill_if #(
  parameter int DFP_WIDTH = 64
);
  logic [31:0]          ufp_addr;
  logic [3:0]           ufp_rmask;
  logic [31:0]          ufp_rdata;
  logic                 ufp_resp;
  logic [31:0]          dfp_addr;
  logic                 dfp_read;
  logic [DFP_WIDTH-1:0] dfp_rdata;
  logic                 dfp_resp;

  // cache side
  modport slave (
    input  ufp_addr, ufp_rmask, dfp_rdata, dfp_resp,
    output ufp_rdata, ufp_resp, dfp_addr, dfp_read
  );

  // fetch stage + memory side
  modport master (
    output ufp_addr, ufp_rmask, dfp_rdata, dfp_resp,
    input  ufp_rdata, ufp_resp, dfp_addr, dfp_read
  );
endinterface
`default_nettype wire

// File: rtl/icache_burst_refill.sv
`default_nettype none
// ----------------------------------------------------------------------------
// icache_burst_refill : read-only set-associative I-cache, burst refill,
//                       sequential flush walk and refill-safe invalidate
// Rev 1.0
// ----------------------------------------------------------------------------
module icache_burst_refill #(
  parameter int WAYS       = 4,
  parameter int SETS       = 16,
  parameter int LINE_BYTES = 32,
  parameter int DFP_WIDTH  = 64
) (
  input  logic                 clk,
  input  logic                 rst_n,
  icache_burst_refill_if.slave bus,
  input  logic                 flush_req,
  output logic                 flush_done,
  input  logic                 invalidate,
  input  logic [31:0]          invalidate_addr
);
  localparam int BEATS      = LINE_BYTES * 8 / DFP_WIDTH;
  localparam int OFF_BITS   = $clog2(LINE_BYTES);
  localparam int SET_BITS   = $clog2(SETS);
  localparam int TAG_BITS   = 32 - SET_BITS - OFF_BITS;
  localparam int WAY_BITS   = (WAYS > 1) ? $clog2(WAYS) : 1;
  localparam int BEAT_BITS  = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int LINE_BITS  = LINE_BYTES * 8;
  localparam int WORD_BITS  = OFF_BITS - 2;
  localparam int BEAT_BYTES = DFP_WIDTH / 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOOKUP = 2'd1,
    REFILL = 2'd2,
    FLUSH  = 2'd3
  } state_t;

  state_t               state;
  logic [TAG_BITS-1:0]  tag_q   [WAYS][SETS];
  logic [LINE_BITS-1:0] data_q  [WAYS][SETS];
  logic                 valid_q [WAYS][SETS];
  logic [WAY_BITS-1:0]  ptr_q   [SETS];
  logic [DFP_WIDTH-1:0] lbuf_q  [BEATS];
  logic [31:0]          req_addr;
  logic [BEAT_BITS-1:0] beat;
  logic                 poison;
  logic                 byp_resp;
  logic [31:0]          byp_data;
  logic [SET_BITS-1:0]  flush_cnt;

  logic [TAG_BITS-1:0]  req_tag, inv_tag;
  logic [SET_BITS-1:0]  req_set, inv_set;
  logic [WORD_BITS-1:0] req_word;
  logic [WAY_BITS-1:0]  victim;
  logic                 inv_same_line, hit_any, hit, ready, last_beat, kill_fill;
  logic [LINE_BITS-1:0] hit_line, fill_line;
  logic                 unused_ok;

  assign req_tag       = req_addr[31 -: TAG_BITS];
  assign req_set       = req_addr[OFF_BITS +: SET_BITS];
  assign req_word      = req_addr[2 +: WORD_BITS];
  assign inv_tag       = invalidate_addr[31 -: TAG_BITS];
  assign inv_set       = invalidate_addr[OFF_BITS +: SET_BITS];
  assign inv_same_line = invalidate && (invalidate_addr[31:OFF_BITS] == req_addr[31:OFF_BITS]);
  assign victim        = ptr_q[req_set];
  assign unused_ok     = ^{req_addr[1:0], invalidate_addr[OFF_BITS-1:0]};

  always_comb begin
    hit_any  = 1'b0;
    hit_line = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (valid_q[w][req_set] && (tag_q[w][req_set] == req_tag)) begin
        hit_any  = 1'b1;
        hit_line = data_q[w][req_set];
      end
    end
  end

  // A same-cycle invalidate of the looked-up line forces a miss.
  assign hit       = (state == LOOKUP) && hit_any && !inv_same_line;
  assign ready     = ((state == IDLE) && !flush_req) || hit;
  assign last_beat = (state == REFILL) && bus.dfp_resp && (beat == BEAT_BITS'(BEATS - 1));
  assign kill_fill = poison || inv_same_line;

  // Line as it will be installed: buffered beats plus the beat arriving now.
  always_comb begin
    fill_line = '0;
    for (int b = 0; b < BEATS; b++) begin
      fill_line[b*DFP_WIDTH +: DFP_WIDTH] = (BEAT_BITS'(b) == beat) ? bus.dfp_rdata : lbuf_q[b];
    end
  end

  assign bus.ufp_resp  = hit || byp_resp;
  assign bus.ufp_rdata = hit      ? hit_line[{req_word, 5'd0} +: 32] :
                         byp_resp ? byp_data : 32'd0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      req_addr     <= '0;
      beat         <= '0;
      poison       <= 1'b0;
      byp_resp     <= 1'b0;
      byp_data     <= '0;
      flush_cnt    <= '0;
      flush_done   <= 1'b0;
      bus.dfp_read <= 1'b0;
      bus.dfp_addr <= '0;
      for (int s = 0; s < SETS; s++) begin
        ptr_q[s] <= '0;
        for (int w = 0; w < WAYS; w++) begin
          valid_q[w][s] <= 1'b0;
          tag_q[w][s]   <= '0;
          data_q[w][s]  <= '0;
        end
      end
      for (int b = 0; b < BEATS; b++) lbuf_q[b] <= '0;
    end else begin
      byp_resp   <= 1'b0;
      flush_done <= 1'b0;
      if (ready) req_addr <= bus.ufp_addr;

      case (state)
        IDLE: begin
          if (flush_req) begin
            state     <= FLUSH;
            flush_cnt <= '0;
          end else if (bus.ufp_rmask != 4'd0) begin
            state <= LOOKUP;
          end
        end
        LOOKUP: begin
          if (hit) begin
            state <= (bus.ufp_rmask != 4'd0) ? LOOKUP : IDLE;
          end else begin
            state        <= REFILL;
            beat         <= '0;
            poison       <= 1'b0;
            bus.dfp_read <= 1'b1;
            bus.dfp_addr <= {req_addr[31:OFF_BITS], {OFF_BITS{1'b0}}};
          end
        end
        REFILL: begin
          if (inv_same_line) poison <= 1'b1;
          if (bus.dfp_resp) begin
            for (int b = 0; b < BEATS; b++) begin
              if (BEAT_BITS'(b) == beat) lbuf_q[b] <= bus.dfp_rdata;
            end
            beat         <= beat + 1'b1;
            bus.dfp_addr <= bus.dfp_addr + 32'(BEAT_BYTES);
          end
          if (last_beat) begin
            bus.dfp_read <= 1'b0;
            for (int w = 0; w < WAYS; w++) begin
              if (WAY_BITS'(w) == victim) begin
                tag_q[w][req_set]   <= req_tag;
                data_q[w][req_set]  <= fill_line;
                valid_q[w][req_set] <= !kill_fill;
              end
            end
            ptr_q[req_set] <= (WAYS > 1) ? victim + 1'b1 : '0;
            // A poisoned line is never made valid; the fetch is served from the buffer.
            if (kill_fill) begin
              byp_resp <= 1'b1;
              byp_data <= fill_line[{req_word, 5'd0} +: 32];
              state    <= IDLE;
            end else begin
              state <= LOOKUP;
            end
          end
        end
        FLUSH: begin
          for (int w = 0; w < WAYS; w++) valid_q[w][flush_cnt] <= 1'b0;
          ptr_q[flush_cnt] <= '0;
          flush_cnt        <= flush_cnt + 1'b1;
          flush_done       <= (flush_cnt == SET_BITS'(SETS - 2));
          if (flush_cnt == SET_BITS'(SETS - 1)) state <= IDLE;
        end
        default: state <= IDLE;
      endcase

      // Placed last so an invalidate overrides an install into the same way.
      if (invalidate) begin
        for (int w = 0; w < WAYS; w++) begin
          if (tag_q[w][inv_set] == inv_tag) valid_q[w][inv_set] <= 1'b0;
        end
      end
    end
  end
endmodule
`default_nettype wire

// File: doc/icache_burst_refill.md
Name: icache_burst_refill

Overview:
- Parametrised successor to the coherent instruction cache: a read-only, set-associative instruction cache with configurable ways, sets and line size.
- Refills run over a narrow memory port in multi-beat bursts.
- Adds a sequential full-flush walk, and single-line invalidation that stays safe during an in-flight refill.
- Sits between the fetch stage (UFP) and the L2/memory arbiter (DFP). It has no snoop bus; coherence is limited to invalidate and flush.

Parameters:
WAYS, 4, associativity; power of 2, ≥1
SETS, 16, number of sets; power of 2, ≥2
LINE_BYTES, 32, cacheline size in bytes; power of 2, ≥8
DFP_WIDTH, 64, refill beat width in bits; power of 2, 32..LINE_BYTES*8
(derived) BEATS = LINE_BYTES*8/DFP_WIDTH; OFF_BITS = log2(LINE_BYTES); SET_BITS = log2(SETS); TAG_BITS = 32-SET_BITS-OFF_BITS

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
ufp_addr  in  32  fetch byte address; bits [1:0] ignored
ufp_rmask  in  4  nonzero = read request
ufp_rdata  out  32  aligned word at ufp_addr_reg[OFF_BITS-1:2]
ufp_resp  out  1  one-cycle response strobe
dfp_addr  out  32  beat address = line base + beat*DFP_WIDTH/8
dfp_read  out  1  refill beat request, held until dfp_resp
dfp_rdata  in  DFP_WIDTH  beat data
dfp_resp  in  1  beat accepted, data valid this cycle
flush_req  in  1  level; held by requester until flush_done
flush_done  out  1  one-cycle pulse when flush walk completes
invalidate  in  1  single-line invalidate strobe, any cycle
invalidate_addr  in  32  line to invalidate; offset bits ignored

Behaviour:
- Storage: flop arrays for tag, data, valid, plus one log2(WAYS)-bit round-robin victim pointer per set. All reset asynchronously: valids 0, pointers 0.
- States: IDLE, LOOKUP, REFILL, FLUSH. Reset → IDLE. Reset outputs: ufp_resp=0, ufp_rdata=0, dfp_read=0, dfp_addr=0, flush_done=0.
- ready = (IDLE & !flush_req) | (LOOKUP & hit). ufp_addr/ufp_rmask are registered only when ready; otherwise ignored. Register with rmask=0 → next state IDLE.
- IDLE: flush_req → FLUSH (flush has priority over a new fetch). Else nonzero rmask → LOOKUP.
- LOOKUP: compare the registered tag against every valid way of the registered set.
  - Hit: ufp_resp=1 and ufp_rdata valid in the same cycle. Hit latency is one cycle after acceptance, so back-to-back hits give one response per cycle. Victim pointer unchanged on a hit.
  - Miss: → REFILL, beat counter = 0, poison = 0.
- REFILL: dfp_read=1, dfp_addr = {tag,set,OFF_BITS'0} + beat*(DFP_WIDTH/8).
  - Each dfp_resp stores dfp_rdata into line-buffer slot [beat] and increments beat.
  - On the last beat (beat == BEATS-1 with dfp_resp): write the full line and tag into the victim way = pointer[set]; valid = !poison; pointer[set] += 1 (wraps mod WAYS).
  - Same edge: if poison=0 → LOOKUP, which hits next cycle. If poison=1 → one cycle with ufp_resp=1 and data taken from the line buffer, then IDLE.
  - Miss latency = BEATS + memory wait + 2 cycles. dfp_read deasserts the cycle after the last dfp_resp.
- invalidate (any state): clear valid of every way in set(invalidate_addr) whose tag matches.
  - In REFILL, if invalidate_addr's line equals the refilling line → poison=1.
  - If invalidate and a refill-install target the same way in the same cycle, the invalidate wins (valid=0).
  - An invalidate coinciding with a LOOKUP of the same line makes that lookup a miss.
- FLUSH: set counter walks 0..SETS-1, one set per cycle, clearing all WAYS valids and that set's pointer. flush_done pulses in the cycle the counter holds SETS-1, then → IDLE. Takes SETS cycles. flush_req is only sampled in IDLE, so a flush requested mid-refill waits until the refill completes.
- Async reset mid-REFILL or mid-FLUSH: immediate return to IDLE, dfp_read=0, line buffer discarded, partial flush abandoned (all valids 0 anyway).

Test Plan:
- Defaults, cold read 0x0000_1004: 4 beats at 0x1000/0x1008/0x1010/0x1018 with dfp_resp after 2 wait cycles each; ufp_resp exactly once, rdata = word 1 of the line; immediate re-read of 0x1004 → ufp_resp the cycle after acceptance.
- Fill 5 distinct tags into set 0 (0x0000, 0x0200, 0x0400, 0x0600, 0x0800): the 5th evicts way 0 (0x0000). Re-read 0x0000 → miss. Re-read 0x0200 → hit.
- Invalidate 0x1000 while beat 2 of a 0x1000 refill is pending: CPU still receives correct data once. A following read of 0x1000 misses and issues 4 new beats.
- Load 16 lines, then hold flush_req: flush_done after 16 cycles in FLUSH; every subsequent read misses. A flush_req raised during a refill completes that refill first.
- Assert rst_n=0 after beat 1 of a refill: dfp_read drops asynchronously, ufp_resp stays 0. After release, a read of the same address misses and refetches from beat 0.
- Sweep DFP_WIDTH=256 (BEATS=1) and LINE_BYTES=64, WAYS=1, SETS=2: same directed hit/miss/evict results and correct beat addresses.
